// File: rtl/pulse_arb_pkg.sv
// Shared state encoding, default parameters and index helper for the pulse channel arbiter.
package pulse_arb_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_CNT_W   = 3;
    localparam int DEF_GAP     = 2;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_REL,
        ST_HOLD
    } arb_state_e;

    // Single wrap is enough: callers never pass an index of 2*n or more.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/pulse_chan_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit strictly after ptr_i, with wrap.
module rr_pick
    import pulse_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  idx_o
);

    int j;

    // Scan the farthest offset first so the nearest requester after the pointer wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = wrap_idx(int'(ptr_i) + k, N_REQ);
            if (req_i[j[ID_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = j[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pulse_chan_arbiter.sv
// Round-robin scheduler sharing one pulse CDC channel among N_REQ requesters.
// Define ARB_TIMEOUT_EN to bound both handshake wait states by TIMEOUT cycles.
module pulse_chan_arbiter
    import pulse_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP     = DEF_GAP,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_pulse,
    output logic             chan_pulse,
    output logic [ID_W-1:0]  chan_id,
    input  logic             chan_ack,
    output logic             busy,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] overflow,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       GAP_LAST = 4'(GAP);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] overflow_q, ovf_set;
    logic [ID_W-1:0]  ptr_q, id_q, pick_idx;
    logic             pick_valid, grant, tmo_hit;
    logic             chan_pulse_q, chan_pulse_d;
    logic [3:0]       hold_q, hold_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i   (pending_q),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             dec, at_max;

        assign dec         = grant && (pick_idx == ID_W'(gi));
        assign at_max      = (cnt_q == CNT_MAX);
        assign ovf_set[gi] = req_pulse[gi] && !dec && at_max;

        // An event arriving with its own grant cancels out and is never counted as dropped.
        always_comb begin
            cnt_d = cnt_q;
            if (req_pulse[gi] && !dec && !at_max) begin
                cnt_d = cnt_q + 1'b1;
            end else if (dec && !req_pulse[gi]) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        assign pending_d[gi] = (cnt_d != '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant   = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (chan_ack) begin
                    state_d = ST_WAIT_REL;
                end else if (tmo_hit) begin
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT_REL: begin
                if (!chan_ack || tmo_hit) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign chan_pulse_d = (state_d == ST_SEND);
    // HOLD lasts GAP+1 cycles; the counter restarts on every entry.
    assign hold_d       = (state_q == ST_HOLD && state_d == ST_HOLD) ? hold_q + 4'd1 : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            chan_pulse_q <= 1'b0;
            pending_q    <= '0;
            overflow_q   <= '0;
            hold_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            chan_pulse_q <= chan_pulse_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_q | ovf_set;
            hold_q       <= hold_d;
            if (grant) begin
                ptr_q <= pick_idx;
                id_q  <= pick_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             timeout_err_q;
    logic             in_wait;

    assign in_wait = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_REL);
    assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT - 1));

    // In WAIT_REL a move to HOLD is only a timeout if the ack is still high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q <= (in_wait && state_d == state_q) ? tmo_q + 1'b1 : '0;
            if (tmo_hit && state_d == ST_HOLD && (state_q == ST_WAIT_ACK || chan_ack)) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign chan_pulse = chan_pulse_q;
    assign chan_id    = id_q;
    assign busy       = (state_q != ST_IDLE);
    assign pending    = pending_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_chan_arbiter.sv
// Bench for pulse_chan_arbiter: cycle table, corner sequences and randomized traffic
// checked against a transaction-level scheduler model with a scripted channel responder.
module tb_pulse_chan_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int MAXC = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_pulse = '0;
    logic         chan_ack = 1'b0;
    logic         chan_pulse, busy, timeout_err;
    logic [1:0]   chan_id;
    logic [N-1:0] pending, overflow;

    pulse_chan_arbiter #(
        .N_REQ   (N),
        .ID_W    (2),
        .CNT_W   (3),
        .GAP     (GAP),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_pulse   (req_pulse),
        .chan_pulse  (chan_pulse),
        .chan_id     (chan_id),
        .chan_ack    (chan_ack),
        .busy        (busy),
        .pending     (pending),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       pulse;
        logic [1:0] id;
        logic       busy;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl[22];

    int total = 0;
    int bad   = 0;

    // Scheduler model: event counts per requester plus a timeline of the current handshake.
    int cnt_m[N];
    bit ovf_m[N];
    int ptr_m, exp_id, cyc;
    int pulse_at, free_at, ack_rise, ack_fall, err_at;
    int dly_lo, dly_hi, hold_lo, hold_hi;
    bit no_ack;
    int obs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            cnt_m[i] = 0;
            ovf_m[i] = 1'b0;
        end
        ptr_m    = N - 1;
        exp_id   = 0;
        cyc      = 0;
        pulse_at = -1;
        free_at  = 0;
        ack_rise = -1;
        ack_fall = -1;
        err_at   = 1 << 30;
    endfunction

    function automatic bit all_zero();
        for (int i = 0; i < N; i++) begin
            if (cnt_m[i] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] rand_req(input int one_in);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ($urandom_range(one_in - 1, 0) == 0);
        return r;
    endfunction

    // Called at the falling edge of cycle cyc: check outputs, advance the model, drive inputs.
    task automatic step(input logic [N-1:0] req, input bit stray);
        logic [N-1:0] pend_v, ovf_v;
        int gid, j;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = (cnt_m[i] > 0);
            ovf_v[i]  = ovf_m[i];
        end
        check("pending", int'(pending), int'(pend_v));
        check("overflow", int'(overflow), int'(ovf_v));
        check("chan_pulse", int'(chan_pulse), int'(cyc == pulse_at));
        check("chan_id", int'(chan_id), exp_id);
        check("busy", int'(busy), int'(cyc >= pulse_at && cyc < free_at));
        check("timeout_err", int'(timeout_err), int'(cyc >= err_at));
        if (chan_pulse) obs.push_back(int'(chan_id));

        gid = -1;
        if (cyc >= free_at) begin
            for (int k = 1; k <= N; k++) begin
                j = (ptr_m + k) % N;
                if (gid < 0 && cnt_m[j] > 0) gid = j;
            end
        end
        if (gid >= 0) begin
            ptr_m    = gid;
            exp_id   = gid;
            pulse_at = cyc + 1;
            if (no_ack) begin
                ack_rise = -1;
                ack_fall = -1;
                err_at   = cyc + 66;
                free_at  = cyc + GAP + 67;
            end else begin
                ack_rise = cyc + 2 + int'($urandom_range(dly_hi, dly_lo));
                ack_fall = ack_rise + 1 + int'($urandom_range(hold_hi, hold_lo));
                free_at  = ack_fall + GAP + 2;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && gid != i) begin
                if (cnt_m[i] == MAXC) ovf_m[i] = 1'b1;
                else cnt_m[i]++;
            end else if (!req[i] && gid == i) begin
                cnt_m[i]--;
            end
        end

        req_pulse = req;
        chan_ack  = (cyc >= ack_rise && cyc < ack_fall) || (stray && cyc >= free_at);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc && !(cyc >= free_at && all_zero())) begin
            step('0, 1'b0);
            n++;
        end
        check("drain_bound", int'(n < max_cyc), 1);
        check("drain_busy", int'(busy), 0);
        check("drain_pending", int'(pending), 0);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_pulse = '0;
        chan_ack  = 1'b0;
        no_ack    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int ones;
        //           req      ack   pulse id    busy  pend
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0100};
        tbl[2]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[3]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[4]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[12] = '{4'b0001, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[13] = '{4'b0001, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0001};
        tbl[14] = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[15] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001};
        tbl[16] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001};
        tbl[17] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001};
        tbl[18] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001};
        tbl[19] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001};
        tbl[20] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001};
        tbl[21] = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};

        dly_lo = 0; dly_hi = 3; hold_lo = 0; hold_hi = 3;
        model_reset();

        // Single request timing, stray ack in IDLE, and a re-request in the grant cycle.
        reset_dut();
        for (int k = 0; k < 22; k++) begin
            cyc = k;
            check("tbl_pulse", int'(chan_pulse), int'(tbl[k].pulse));
            check("tbl_id", int'(chan_id), int'(tbl[k].id));
            check("tbl_busy", int'(busy), int'(tbl[k].busy));
            check("tbl_pending", int'(pending), int'(tbl[k].pend));
            check("tbl_overflow", int'(overflow), 0);
            check("tbl_timeout", int'(timeout_err), 0);
            req_pulse = tbl[k].req;
            chan_ack  = tbl[k].ack;
            @(negedge clk);
        end

        // All four requesters at once are served in index order.
        reset_dut();
        obs.delete();
        dly_lo = 0; dly_hi = 3; hold_lo = 0; hold_hi = 2;
        step(4'b1111, 1'b0);
        drain(300);
        check("burst_count", obs.size(), 4);
        for (int i = 0; i < 4; i++) check("burst_order", (i < obs.size()) ? obs[i] : -1, i);

        // Saturation while the channel is stalled, then exactly MAXC grants to requester 1.
        reset_dut();
        obs.delete();
        dly_lo = 20; dly_hi = 20; hold_lo = 1; hold_hi = 1;
        step(4'b0001, 1'b0);
        repeat (8) step(4'b0010, 1'b0);
        step('0, 1'b0);
        check("ovf_flag", int'(overflow), 4'b0010);
        dly_lo = 0; dly_hi = 2;
        drain(400);
        ones = 0;
        foreach (obs[i]) if (obs[i] == 1) ones++;
        check("ovf_grants_1", ones, MAXC);
        check("ovf_sticky", int'(overflow), 4'b0010);

        // Asynchronous reset in the middle of WAIT_REL.
        reset_dut();
        dly_lo = 0; dly_hi = 0; hold_lo = 10; hold_hi = 10;
        step(4'b1111, 1'b0);
        repeat (5) step('0, 1'b0);
        #2;
        rst_n     = 1'b0;
        req_pulse = '0;
        chan_ack  = 1'b0;
        #1;
        check("rst_pulse", int'(chan_pulse), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_id", int'(chan_id), 0);
        check("rst_timeout", int'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        obs.delete();
        dly_lo = 0; dly_hi = 2; hold_lo = 0; hold_hi = 2;
        step(4'b1001, 1'b0);
        drain(100);
        check("post_rst_count", obs.size(), 2);
        check("post_rst_first", (obs.size() > 0) ? obs[0] : -1, 0);
        check("post_rst_second", (obs.size() > 1) ? obs[1] : -1, 3);

        // Random traffic: light load with stray acks, then heavy load to hit saturation.
        reset_dut();
        dly_lo = 0; dly_hi = 3; hold_lo = 0; hold_hi = 3;
        for (int i = 0; i < 1500; i++) step(rand_req(6), ($urandom_range(3, 0) == 0));
        for (int i = 0; i < 800; i++) step(rand_req(2), ($urandom_range(3, 0) == 0));
        drain(2000);

`ifdef ARB_TIMEOUT_EN
        // Channel never acknowledges: timeout, then normal service resumes.
        reset_dut();
        no_ack = 1'b1;
        step(4'b0100, 1'b0);
        repeat (70) step('0, 1'b0);
        check("timeout_flag", int'(timeout_err), 1);
        no_ack = 1'b0;
        obs.delete();
        step(4'b0001, 1'b0);
        drain(200);
        check("timeout_next_count", obs.size(), 1);
        check("timeout_next_id", (obs.size() > 0) ? obs[0] : -1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pulse_chan_arbiter.md
# pulse_chan_arbiter

Round-robin scheduler sharing one pulse clock-domain-crossing channel among N source-domain requesters. Counts pending events per requester, grants one at a time, drives a single-cycle launch pulse plus requester ID into the channel, then runs the channel's four-phase return handshake before the next grant. Sits entirely in the source clock domain, in front of the pulse synchronizer and its ID side-band register.

## Interface
- N_REQ, 4: number of requesters (2..16).
- ID_W, $clog2(N_REQ): width of chan_id.
- CNT_W, 3: pending-counter width per requester; saturates at 2^CNT_W-1.
- GAP, 2: idle cycles enforced after handshake release (0..15).
- TIMEOUT, 64: cycles allowed in each wait state (timeout build only).

- clk  in  1  source-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_pulse  in  N_REQ  one-cycle event per requester; any subset may fire in the same cycle.
- chan_pulse  out  1  one-cycle launch strobe to the channel.
- chan_id  out  ID_W  granted requester; stable from chan_pulse until return to IDLE.
- chan_ack  in  1  channel return handshake, already synchronized into clk.
- busy  out  1  high in any state other than IDLE.
- pending  out  N_REQ  bit i high when counter i is non-zero.
- overflow  out  N_REQ  sticky; bit i set when an event hits saturated counter i.
- timeout_err  out  1  sticky timeout flag (forced 0 when feature absent).

## Operation
- Reset: all counters 0, FSM IDLE, chan_pulse 0, chan_id 0, busy 0, pending 0, overflow 0, timeout_err 0, RR pointer N_REQ-1, so requester 0 has first priority.
- Counter i: +1 on req_pulse[i]; -1 on grant to i; both in the same cycle leave it unchanged. At max, a new event is dropped and overflow[i] sets. Overflow clears only on reset.
- FSM states: IDLE, SEND, WAIT_ACK, WAIT_REL, HOLD.
- IDLE: if any counter non-zero, pick the first non-zero index scanning upward from pointer+1 with wrap. Latch it into chan_id and the pointer, decrement its counter, go to SEND.
- SEND: chan_pulse=1 for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK: wait for chan_ack=1, then go to WAIT_REL.
- WAIT_REL: wait for chan_ack=0, then go to HOLD.
- HOLD: count GAP cycles, then go to IDLE. GAP=0 makes HOLD a single cycle.
- chan_ack high while in IDLE or SEND is ignored. An ack must be observed in WAIT_ACK.
- A requester is never granted twice in a row while another counter is non-zero.

## Timing
- req_pulse in cycle t updates the counter at t+1.
- With the FSM in IDLE, the grant occurs at t+1 and chan_pulse is high in cycle t+2. chan_pulse is registered.
- Minimum grant-to-grant period is 5+GAP cycles plus ack latency in each direction.
- pending and overflow are registered and reflect the counter state one cycle after the event.
- busy rises in the same cycle as SEND.
- Asynchronous reset mid-handshake returns to IDLE immediately. The channel is reset by the same rst_n, so no stale ack remains.

## Configuration
- ARB_TIMEOUT_EN defined: a counter runs in WAIT_ACK and WAIT_REL and restarts on each state entry.
  - Reaching TIMEOUT cycles sets timeout_err and moves to HOLD.
  - The aborted event is not re-queued.
- ARB_TIMEOUT_EN undefined: no timeout counter; the wait states are unbounded; timeout_err is tied to 0.

## Structure
- Shared package pulse_arb_pkg:
  - FSM state enum arb_state_e.
  - Defaults for N_REQ, CNT_W, GAP, TIMEOUT.
- One sub-module, rr_pick:
  - Combinational round-robin first-set search.
  - Inputs: request vector and pointer.
  - Outputs: valid flag and index.
- Counters, FSM and timeout logic live in the top level.

## Test plan
- Reset release, then req_pulse[2] at t=10 with ack returning 3 cycles after chan_pulse → chan_pulse at t=12 with chan_id=2; busy 12..; pending[2] high only at t=11.
- req_pulse=4'b1111 in one cycle → grants in order 0,1,2,3; each chan_pulse exactly one cycle; next grant only after ack fall plus GAP.
- Eight pulses on req 1 with CNT_W=3 while handshake stalled → counter reaches 7 and overflow[1] sets; after release exactly 7 grants to ID 1.
- req_pulse[0] in the same cycle as its grant → count stays unchanged and a second grant to 0 follows.
- Assert rst_n low during WAIT_REL → all outputs 0 and IDLE immediately; a fresh request after release grants requester 0.
- ARB_TIMEOUT_EN defined, TIMEOUT=64, chan_ack held 0 → timeout_err at 64 cycles into WAIT_ACK, then HOLD and IDLE; the next pending request is granted normally.
